// File: rtl/ecc_pkg.sv
// Shared secp256k1 constants and the Jacobian-to-affine FSM state encoding.
package ecc_pkg;

    localparam int COORD_W = 256;

    // Field prime p = 2^256 - 2^32 - 977.
    localparam logic [COORD_W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // Fermat exponent for inversion: z^(p-2) = z^-1 mod p.
    localparam logic [COORD_W-1:0] P_MINUS_2 = P - 256'd2;

    // Multiplications spent on the inversion ladder (255 squarings + 248 multiplies).
    localparam int INV_MULS = 503;

    // Cycles from a start_mul pulse to the matching mul_done pulse.
    localparam int MUL_LAT = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ZCHK,
        ST_INV_SQ,
        ST_INV_MUL,
        ST_ZI2,
        ST_XAFF,
        ST_ZI3,
        ST_YAFF,
        ST_FIN
    } j2a_state_e;

endpackage

// File: rtl/mod_mul.sv
// Pipelined modular multiplier for the secp256k1 field.
// Reduction uses 2^256 == C (mod p) with C = 2^256 - p, a 33-bit constant,
// so two folds plus one conditional subtract bring the product below p.
module mod_mul
    import ecc_pkg::*;
#(
    parameter logic [COORD_W-1:0] MOD = ecc_pkg::P
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_mul,
    input  logic [COORD_W-1:0] a,
    input  logic [COORD_W-1:0] b,
    output logic               mul_done,
    output logic [COORD_W-1:0] mul_result
);

    localparam logic [COORD_W-1:0] C_FULL = ~MOD + 256'd1;
    localparam logic [32:0]        C      = C_FULL[32:0];

    logic                 v1_q, v2_q, v3_q;
    logic [511:0]         prod_q;
    logic [289:0]         s1_q;
    logic [COORD_W-1:0]   res_q;

    logic [511:0]         prod_d;
    logic [289:0]         s1_d;
    logic [33:0]          h2;
    logic [256:0]         s2;
    logic [COORD_W-1:0]   s3;
    logic [COORD_W-1:0]   res_d;

    // First fold: hi*2^256 + lo becomes lo + hi*C (< 2^290).
    // Second fold brings it to < 2^257; a final carry fold and compare land below p.
    always_comb begin
        prod_d = {256'd0, a} * {256'd0, b};
        s1_d   = {34'd0, prod_q[255:0]} + ({34'd0, prod_q[511:256]} * {257'd0, C});
        h2     = s1_q[289:256];
        s2     = {1'b0, s1_q[255:0]} + ({223'd0, h2} * {224'd0, C});
        s3     = s2[255:0] + (s2[256] ? {223'd0, C} : 256'd0);
        res_d  = (s3 >= MOD) ? (s3 - MOD) : s3;
    end

    // Three-stage pipeline: product, first fold, second fold + final correction.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            prod_q <= '0;
            s1_q   <= '0;
            res_q  <= '0;
        end else begin
            v1_q   <= start_mul;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            prod_q <= prod_d;
            s1_q   <= s1_d;
            res_q  <= res_d;
        end
    end

    assign mul_done   = v3_q;
    assign mul_result = res_q;

endmodule

// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) to affine (x,y) conversion over the secp256k1 field.
// Z^-1 comes from a left-to-right square-and-multiply ladder on p-2; every
// product, including the ladder, goes through one shared mod_mul.
module jacobian_to_affine
    import ecc_pkg::*;
#(
    parameter int                 WIDTH = COORD_W,
    parameter logic [COORD_W-1:0] P     = ecc_pkg::P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             inf,
    output logic             busy,
    output logic             done
);

    j2a_state_e       state_q, state_d;
    logic [WIDTH-1:0] xin_q, xin_d;
    logic [WIDTH-1:0] yin_q, yin_d;
    logic [WIDTH-1:0] zin_q, zin_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] zi2_q, zi2_d;
    logic [WIDTH-1:0] zi3_q, zi3_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             inf_q, inf_d;
    logic [7:0]       k_q, k_d;
    logic             start_mul_q, start_mul_d;

    logic [WIDTH-1:0] op_a, op_b;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;

    mod_mul #(
        .MOD (P)
    ) u_mod_mul (
        .clk        (clk),
        .rst        (rst),
        .start_mul  (start_mul_q),
        .a          (op_a),
        .b          (op_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    // Operand select: each multiplying state owns a fixed operand pair.
    always_comb begin
        op_a = acc_q;
        op_b = acc_q;
        case (state_q)
            ST_INV_MUL: begin op_a = acc_q; op_b = zin_q; end
            ST_XAFF:    begin op_a = xin_q; op_b = zi2_q; end
            ST_ZI3:     begin op_a = zi2_q; op_b = acc_q; end
            ST_YAFF:    begin op_a = yin_q; op_b = zi3_q; end
            default:    begin op_a = acc_q; op_b = acc_q; end
        endcase
    end

    // Next-state logic; a new multiply is launched on every transition into
    // (or re-entry of) a multiplying state, so each product costs L+1 cycles.
    always_comb begin
        state_d     = state_q;
        xin_d       = xin_q;
        yin_d       = yin_q;
        zin_d       = zin_q;
        acc_d       = acc_q;
        zi2_d       = zi2_q;
        zi3_d       = zi3_q;
        x_d         = x_q;
        y_d         = y_q;
        inf_d       = inf_q;
        k_d         = k_q;
        start_mul_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xin_d   = X;
                    yin_d   = Y;
                    zin_d   = Z;
                    x_d     = '0;
                    y_d     = '0;
                    inf_d   = 1'b0;
                    state_d = ST_ZCHK;
                end
            end
            ST_ZCHK: begin
                if (zin_q == '0) begin
                    inf_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    // The exponent's top bit is absorbed by starting from acc = Z.
                    acc_d       = zin_q;
                    k_d         = 8'd254;
                    start_mul_d = 1'b1;
                    state_d     = ST_INV_SQ;
                end
            end
            ST_INV_SQ: begin
                if (mul_done) begin
                    acc_d       = mul_result;
                    start_mul_d = 1'b1;
                    if (P_MINUS_2[k_q]) begin
                        state_d = ST_INV_MUL;
                    end else if (k_q == 8'd0) begin
                        state_d = ST_ZI2;
                    end else begin
                        k_d = k_q - 8'd1;
                    end
                end
            end
            ST_INV_MUL: begin
                if (mul_done) begin
                    acc_d       = mul_result;
                    start_mul_d = 1'b1;
                    if (k_q == 8'd0) begin
                        state_d = ST_ZI2;
                    end else begin
                        k_d     = k_q - 8'd1;
                        state_d = ST_INV_SQ;
                    end
                end
            end
            ST_ZI2: begin
                if (mul_done) begin
                    zi2_d       = mul_result;
                    start_mul_d = 1'b1;
                    state_d     = ST_XAFF;
                end
            end
            ST_XAFF: begin
                if (mul_done) begin
                    x_d         = mul_result;
                    start_mul_d = 1'b1;
                    state_d     = ST_ZI3;
                end
            end
            ST_ZI3: begin
                if (mul_done) begin
                    zi3_d       = mul_result;
                    start_mul_d = 1'b1;
                    state_d     = ST_YAFF;
                end
            end
            ST_YAFF: begin
                if (mul_done) begin
                    y_d     = mul_result;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            xin_q       <= '0;
            yin_q       <= '0;
            zin_q       <= '0;
            acc_q       <= '0;
            zi2_q       <= '0;
            zi3_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            inf_q       <= 1'b0;
            k_q         <= '0;
            start_mul_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xin_q       <= xin_d;
            yin_q       <= yin_d;
            zin_q       <= zin_d;
            acc_q       <= acc_d;
            zi2_q       <= zi2_d;
            zi3_q       <= zi3_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inf_q       <= inf_d;
            k_q         <= k_d;
            start_mul_q <= start_mul_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign inf  = inf_q;
    assign done = (state_q == ST_FIN);
    assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);

endmodule

// File: tb/tb_jacobian_to_affine.sv
// Scoreboard bench for jacobian_to_affine. Random cases are built backwards
// from a random affine point and random Z (X = x*Z^2, Y = y*Z^3), so the
// reference never needs an inversion.
module tb_jacobian_to_affine;

    localparam logic [255:0] PM =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] G2X =
        256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [255:0] G2Y =
        256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
    localparam int LAT_FULL = 507 * (ecc_pkg::MUL_LAT + 1) + 2;
    localparam int LIMIT    = 4000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] X = '0, Y = '0, Z = '0;
    logic [255:0] x, y;
    logic         inf, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [255:0] ex;
        logic [255:0] ey;
        logic         einf;
        int           acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    jacobian_to_affine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .x     (x),
        .y     (y),
        .inf   (inf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference field arithmetic ----------------
    function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'd0, a} * {256'd0, b}) % {256'd0, PM};
        return t[255:0];
    endfunction

    function automatic logic [255:0] madd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, PM}) t = t - {1'b0, PM};
        return t[255:0];
    endfunction

    function automatic logic [255:0] msub(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + {1'b0, PM} - {1'b0, b};
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if (r >= PM) r = r - PM;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done at cycle %0d (no transaction outstanding)", cyc);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.acc_cyc + 1;
                chk("x", x, e.ex);
                chk("y", y, e.ey);
                chk("inf", 256'(inf), 256'(e.einf));
                chk("busy_low_at_done", 256'(busy), 256'd0);
                chk("latency", 256'(lat), e.einf ? 256'd2 : 256'(LAT_FULL));
                $display("txn: x=%h y=%h inf=%0d latency=%0d", x, y, inf, lat);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [255:0] xi, input logic [255:0] yi, input logic [255:0] zi,
                         input logic [255:0] ex, input logic [255:0] ey, input logic einf,
                         input bit poke_busy);
        for (int i = 0; i < 50 && (busy || done); i++) @(negedge clk);
        @(posedge clk); #1;
        X = xi; Y = yi; Z = zi;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back('{ex, ey, einf, cyc});
        chk("busy_rise", 256'(busy), 256'd1);
        // Inputs must have been latched; scramble them now.
        X = rand_fe(); Y = rand_fe(); Z = rand_fe();
        if (poke_busy && !einf) begin
            repeat (5) @(posedge clk);
            #1;
            Z = '0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < LIMIT);
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout after %0d cycles", cnt);
            exp_q.delete();
        end else begin
            // start in the done cycle must be ignored
            X = rand_fe(); Y = rand_fe(); Z = '0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("done_cycle_start_ignored_busy", 256'(busy), 256'd0);
            chk("done_cycle_start_ignored_done", 256'(done), 256'd0);
        end
    endtask

    task automatic convert(input logic [255:0] xi, input logic [255:0] yi, input logic [255:0] zi,
                           input logic [255:0] ex, input logic [255:0] ey, input logic einf,
                           input bit poke_busy);
        issue(xi, yi, zi, ex, ey, einf, poke_busy);
        wait_done();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [255:0] ax, ay, az, z2, z3;
        logic [255:0] dx, dy, dz, s, m, y2;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_x", x, 256'd0);
        chk("reset_y", y, 256'd0);
        chk("reset_inf", 256'(inf), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_done", 256'(done), 256'd0);

        // Generator with Z = 1
        convert(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);

        // Scaled generator, Z = 2
        convert(mmul(256'd4, GX), mmul(256'd8, GY), 256'd2, GX, GY, 1'b0, 1'b1);

        // Z = p - 1
        convert(GX, PM - GY, PM - 256'd1, GX, GY, 1'b0, 1'b0);

        // Jacobian doubling of (G, Z=1): S=4XY^2, M=3X^2, X3=M^2-2S,
        // Y3=M(S-X3)-8Y^4, Z3=2Y.
        y2 = mmul(GY, GY);
        s  = mmul(256'd4, mmul(GX, y2));
        m  = mmul(256'd3, mmul(GX, GX));
        dx = msub(mmul(m, m), madd(s, s));
        dy = msub(mmul(m, msub(s, dx)), mmul(256'd8, mmul(y2, y2)));
        dz = madd(GY, GY);
        convert(dx, dy, dz, G2X, G2Y, 1'b0, 1'b0);

        // Z = 0, then a valid point
        convert(GX, GY, 256'd0, 256'd0, 256'd0, 1'b1, 1'b0);
        convert(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);

        // Random points
        for (int t = 0; t < 5; t++) begin
            ax = rand_fe();
            ay = rand_fe();
            do az = rand_fe(); while (az == '0);
            z2 = mmul(az, az);
            z3 = mmul(z2, az);
            convert(mmul(ax, z2), mmul(ay, z3), az, ax, ay, 1'b0, bit'(t[0]));
        end

        // Reset in the middle of the ladder (around multiplication 100)
        issue(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);
        repeat (100 * (ecc_pkg::MUL_LAT + 1)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("midreset_x", x, 256'd0);
        chk("midreset_y", y, 256'd0);
        chk("midreset_inf", 256'(inf), 256'd0);
        chk("midreset_busy", 256'(busy), 256'd0);
        chk("midreset_done", 256'(done), 256'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", 256'(done), 256'd0);
        end
        convert(GX, GY, 256'd1, GX, GY, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
